di_host_seq: RTL
================

Name: di_host_seq

Overview:
DI-bus initiator that turns single register commands into DI transactions toward any register terminal, such as the CircleCropTest terminal.
- Accepts one command at a time from a valid/ready command port.
- Drives the di_* request signals and waits on the terminal's rdy/en/status.
- Returns read data plus a completion status on a valid/ready response port.
- Used by on-chip bring-up logic and sim benches to program imager blocks (enable, overage, etc.) without a host PC.

Parameters:
TIMEOUT_CYCLES, 1024, cycles to wait for di_read_rdy/di_write_rdy before aborting (only with the optional feature).
SETUP_CYCLES, 1, cycles that addresses/mode are held stable before the first strobe (minimum 1).

Ports:
di_clk  in  1  sole clock
resetb  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_term  in  16  target terminal address
cmd_addr  in  32  register address
cmd_data  in  32  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
rsp_data  out  32  read data (0 for writes)
rsp_status  out  2  0=OK, 1=NO_TERM (di_en low), 2=XFER_ERR (di_transfer_status!=0), 3=TIMEOUT
di_term_addr  out  16  terminal address
di_reg_addr  out  32  register address
di_reg_datai  out  32  write data to terminal
di_write_mode  out  1  held high for the whole write transaction
di_write  out  1  one-cycle write strobe
di_read_mode  out  1  held high for the whole read transaction
di_read_req  out  1  one-cycle read request pulse
di_read  out  1  one-cycle read strobe, data sampled same cycle
di_write_rdy  in  1  terminal can take write
di_read_rdy  in  1  terminal read data valid
di_reg_datao  in  32  terminal read data
di_transfer_status  in  16  nonzero = error
di_en  in  1  addressed terminal exists

Behaviour:
- Reset: every output is 0 except cmd_ready=1. The FSM goes to IDLE and the timeout counter clears.
- IDLE:
  - cmd_ready=1.
  - On accept, register cmd_term/addr/data onto the di_* address/data outputs.
  - Raise di_write_mode or di_read_mode, then go to SETUP.
  - cmd_ready drops the cycle after accept.
- SETUP:
  - Hold for SETUP_CYCLES.
  - At the end, sample di_en. If di_en=0, drop the mode and go to DONE with NO_TERM; no strobe is ever issued.
  - Otherwise go to WR_WAIT (write) or RD_REQ (read).
- WR_WAIT:
  - First cycle with di_write_rdy=1: di_write=1 for exactly that cycle.
  - Capture di_transfer_status that same cycle: OK if 0, else XFER_ERR. Go to DONE.
- RD_REQ: di_read_req=1 for one cycle, then go to RD_WAIT.
- RD_WAIT:
  - First cycle with di_read_rdy=1: di_read=1 for that cycle.
  - Capture rsp_data=di_reg_datao and the status as in WR_WAIT. Go to DONE.
- DONE:
  - Modes low, rsp_valid=1, and rsp_data/rsp_status stable until rsp_ready.
  - On handshake, return to IDLE with cmd_ready=1 the next cycle.
  - No command is accepted while rsp_valid=1.
- Minimum latency, accept to rsp_valid: 1+SETUP_CYCLES+1 for writes; 1+SETUP_CYCLES+2 for reads (rdy already high).
- Address, data and mode outputs stay constant from SETUP through the strobe cycle.
- rsp_data is 0 for writes, NO_TERM and TIMEOUT.
- Strobes never overlap. At most one strobe of each kind is issued per command.
- resetb assertion mid-transaction returns all outputs to reset values immediately; no response is produced for the aborted command.
- rdy inputs are ignored outside the WAIT states.

Optional Feature:
DI_HOST_TIMEOUT_EN.
- When defined: a 16-bit counter clears on entering WR_WAIT/RD_WAIT and increments each waiting cycle. When it reaches TIMEOUT_CYCLES-1 with rdy still low, the block drops the mode without a strobe and goes to DONE with TIMEOUT.
- When undefined: no counter; WR_WAIT/RD_WAIT wait indefinitely, and status 3 never occurs.

Test Plan:
- Write term=0x0010, addr=4, data=0x1, rdy=1, en=1, status=0 -> exactly one di_write pulse with di_reg_datai=0x1; rsp_valid at cycle 3 after accept; rsp_status=0.
- Read addr=8, di_reg_datao=0xDEADBEEF, di_read_rdy held low 5 cycles -> one di_read_req, then di_read on the first rdy cycle; rsp_data=0xDEADBEEF, status 0.
- Write to a term with di_en=0 -> no di_write/di_read_req; rsp_status=1, rsp_data=0.
- Read with di_transfer_status=1 -> rsp_status=2; the strobe is still issued once.
- With DI_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16, di_write_rdy stuck 0 -> no di_write; rsp_status=3 after 16 wait cycles; the next command is accepted normally.
- Backpressure: rsp_ready low for 10 cycles while cmd_valid is high -> cmd_ready stays 0 and rsp fields stay stable; resetb pulse during RD_WAIT -> all outputs return to reset values, cmd_ready=1.

Source files
------------

// File: rtl/di_host_seq.sv
// di_host_seq: DI-bus initiator that runs one register read/write per accepted command.
// Optional macro DI_HOST_TIMEOUT_EN adds a TIMEOUT_CYCLES abort on the rdy waits.
module di_host_seq #(
   parameter int unsigned SETUP_CYCLES = 1
`ifdef DI_HOST_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic        di_clk,
   input  logic        resetb,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [15:0] cmd_term,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_status,
   output logic [15:0] di_term_addr,
   output logic [31:0] di_reg_addr,
   output logic [31:0] di_reg_datai,
   output logic        di_write_mode,
   output logic        di_write,
   output logic        di_read_mode,
   output logic        di_read_req,
   output logic        di_read,
   input  logic        di_write_rdy,
   input  logic        di_read_rdy,
   input  logic [31:0] di_reg_datao,
   input  logic [15:0] di_transfer_status,
   input  logic        di_en
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_DONE
   } state_t;

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_NO_TERM = 2'd1;
   localparam logic [1:0] ST_XFER    = 2'd2;
`ifdef DI_HOST_TIMEOUT_EN
   localparam logic [1:0] ST_TMO     = 2'd3;
   localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
`endif

   // A setup length of 0 would let the strobe race the address change.
   localparam int unsigned SETUP_N = (SETUP_CYCLES < 1) ? 1 : SETUP_CYCLES;
   localparam int          SCW     = $clog2(SETUP_N + 1);
   localparam logic [SCW-1:0] SETUP_LAST = SCW'(SETUP_N - 1);

   state_t          state_q, state_d;
   logic            wr_q, wr_d;
   logic [15:0]     term_q, term_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [1:0]      status_q, status_d;
   logic [SCW-1:0]  setup_cnt_q, setup_cnt_d;
`ifdef DI_HOST_TIMEOUT_EN
   logic [15:0]     tmo_q, tmo_d;
`endif

   always_ff @(posedge di_clk or negedge resetb) begin
      if (!resetb) begin
         state_q     <= S_IDLE;
         wr_q        <= 1'b0;
         term_q      <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         status_q    <= ST_OK;
         setup_cnt_q <= '0;
`ifdef DI_HOST_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         term_q      <= term_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         status_q    <= status_d;
         setup_cnt_q <= setup_cnt_d;
`ifdef DI_HOST_TIMEOUT_EN
         tmo_q       <= tmo_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      term_d      = term_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      status_d    = status_q;
      setup_cnt_d = setup_cnt_q;
`ifdef DI_HOST_TIMEOUT_EN
      tmo_d       = tmo_q;
`endif
      di_write    = 1'b0;
      di_read_req = 1'b0;
      di_read     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               wr_d        = cmd_write;
               term_d      = cmd_term;
               addr_d      = cmd_addr;
               wdata_d     = cmd_data;
               rdata_d     = '0;
               status_d    = ST_OK;
               setup_cnt_d = '0;
               state_d     = S_SETUP;
            end
         end
         S_SETUP: begin
            if (setup_cnt_q == SETUP_LAST) begin
`ifdef DI_HOST_TIMEOUT_EN
               tmo_d = '0;
`endif
               if (!di_en) begin
                  status_d = ST_NO_TERM;
                  state_d  = S_DONE;
               end else begin
                  state_d = wr_q ? S_WR_WAIT : S_RD_REQ;
               end
            end else begin
               setup_cnt_d = setup_cnt_q + 1'b1;
            end
         end
         S_WR_WAIT: begin
            if (di_write_rdy) begin
               di_write = 1'b1;
               status_d = (|di_transfer_status) ? ST_XFER : ST_OK;
               state_d  = S_DONE;
            end
`ifdef DI_HOST_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
               status_d = ST_TMO;
               state_d  = S_DONE;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
`endif
         end
         S_RD_REQ: begin
            di_read_req = 1'b1;
`ifdef DI_HOST_TIMEOUT_EN
            tmo_d = '0;
`endif
            state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (di_read_rdy) begin
               di_read  = 1'b1;
               rdata_d  = di_reg_datao;
               status_d = (|di_transfer_status) ? ST_XFER : ST_OK;
               state_d  = S_DONE;
            end
`ifdef DI_HOST_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
               status_d = ST_TMO;
               state_d  = S_DONE;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
`endif
         end
         S_DONE: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Modes follow the state so they fall the same cycle DONE is entered.
   assign di_write_mode = wr_q & ((state_q == S_SETUP) | (state_q == S_WR_WAIT));
   assign di_read_mode  = ~wr_q & ((state_q == S_SETUP) | (state_q == S_RD_REQ) |
                                   (state_q == S_RD_WAIT));
   assign cmd_ready     = (state_q == S_IDLE);
   assign rsp_valid     = (state_q == S_DONE);
   assign rsp_data      = rdata_q;
   assign rsp_status    = status_q;
   assign di_term_addr  = term_q;
   assign di_reg_addr   = addr_q;
   assign di_reg_datai  = wdata_q;

endmodule
